// File: rtl/gate_tt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gate_tt_pkg
// Purpose  : Shared types and constants for the 2-input gate truth-table
//            checker: FSM state encoding, vector count, counter width and
//            reference truth tables for common gate cells.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package gate_tt_pkg;

    // Run-control states of the checker.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Number of input vectors of a 2-input cell.
    localparam int NUM_VEC = 4;

    // Width of the settle counter; holds SETTLE_CYCLES-1 for 1..15.
    localparam int CNT_W = 4;

    // Reference truth tables; bit i is f for vector i = {a,b}.
    localparam logic [NUM_VEC-1:0] TT_NOR  = 4'b0001;
    localparam logic [NUM_VEC-1:0] TT_NAND = 4'b0111;
    localparam logic [NUM_VEC-1:0] TT_AND  = 4'b1000;
    localparam logic [NUM_VEC-1:0] TT_OR   = 4'b1110;
    localparam logic [NUM_VEC-1:0] TT_XOR  = 4'b0110;

endpackage : gate_tt_pkg
`default_nettype wire

// File: rtl/gate_tt_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : gate_tt_checker_if
// Purpose  : Bundles the run-control handshake, gate stimulus/response and
//            result signals of the truth-table checker.
// Signals  : start       - run request (harness -> checker)
//            f           - gate-under-test output (gate -> checker)
//            a, b        - gate inputs (checker -> gate)
//            busy, done  - run status (checker -> harness)
//            pass        - last run matched the expected table
//            fail_mask   - per-vector mismatch of the last run
//            observed_tt - captured f per vector of the last run
// Modports : master - harness/gate side; slave - checker side
// Revision : 1.0 - initial release
// ============================================================================
interface gate_tt_checker_if;
    import gate_tt_pkg::*;

    logic               start;
    logic               f;
    logic               a;
    logic               b;
    logic               busy;
    logic               done;
    logic               pass;
    logic [NUM_VEC-1:0] fail_mask;
    logic [NUM_VEC-1:0] observed_tt;

    modport master (
        output start, f,
        input  a, b, busy, done, pass, fail_mask, observed_tt
    );

    modport slave (
        input  start, f,
        output a, b, busy, done, pass, fail_mask, observed_tt
    );

endinterface : gate_tt_checker_if
`default_nettype wire

// File: rtl/settle_timer.sv
`default_nettype none
// ============================================================================
// Module   : settle_timer
// Purpose  : Loadable down-counter with a zero flag; times how long each
//            vector is held before the gate output is sampled.
// Ports    : clk        - rising-edge clock
//            rst_n      - asynchronous active-low reset (count -> 0)
//            load_i     - load load_val_i (has priority over dec_i)
//            load_val_i - reload value
//            dec_i      - decrement by one
//            zero_o     - count is zero
// Revision : 1.0 - initial release
// ============================================================================
module settle_timer #(
    parameter int CNT_W = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load_i,
    input  wire logic [CNT_W-1:0] load_val_i,
    input  wire logic             dec_i,
    output logic                  zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule : settle_timer
`default_nettype wire

// File: rtl/gate_tt_checker.sv
`default_nettype none
// ============================================================================
// Module   : gate_tt_checker
// Purpose  : Drives the four input vectors {a,b}=00,01,10,11 into a 2-input
//            gate, holds each for SETTLE_CYCLES cycles, samples f, and
//            compares the captured truth table against EXP_TT.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - gate_tt_checker_if.slave (start, f in; a, b, busy,
//                    done, pass, fail_mask, observed_tt out)
// Params   : EXP_TT        - expected truth table (bit i = f for vector i)
//            SETTLE_CYCLES - hold cycles before sampling, 1..15
// Revision : 1.0 - initial release
// ============================================================================
module gate_tt_checker
    import gate_tt_pkg::*;
#(
    parameter logic [NUM_VEC-1:0] EXP_TT        = TT_NOR,
    parameter int                 SETTLE_CYCLES = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    gate_tt_checker_if.slave   bus
);

    // Counter is loaded with one less than the hold time because the
    // terminal (zero) cycle itself is part of SETTLE.
    localparam logic [CNT_W-1:0] c_reload = CNT_W'(SETTLE_CYCLES - 1);

    state_t             state_q, state_d;
    logic [1:0]         vec_q, vec_d;
    logic [1:0]         ab_q, ab_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [NUM_VEC-1:0] fail_mask_q, fail_mask_d;
    logic [NUM_VEC-1:0] obs_q, obs_d;

    logic [NUM_VEC-1:0] w_obs_final;
    logic               w_timer_load;
    logic               w_timer_dec;
    logic               w_timer_zero;

    settle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (w_timer_load),
        .load_val_i (c_reload),
        .dec_i      (w_timer_dec),
        .zero_o     (w_timer_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_q       <= 2'd0;
            ab_q        <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= '0;
            obs_q       <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            ab_q        <= ab_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_mask_q <= fail_mask_d;
            obs_q       <= obs_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        ab_d         = ab_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        fail_mask_d  = fail_mask_q;
        obs_d        = obs_q;
        w_timer_load = 1'b0;
        w_timer_dec  = 1'b0;

        // Table including the sample taken at this edge; the final verdict
        // must see vector 3's f, not the stale bit.
        w_obs_final        = obs_q;
        w_obs_final[vec_q] = bus.f;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d      = SETTLE;
                    vec_d        = 2'd0;
                    ab_d         = 2'd0;
                    w_timer_load = 1'b1;
                    pass_d       = 1'b0;
                    fail_mask_d  = '0;
                    obs_d        = '0;
                end
            end
            SETTLE: begin
                if (w_timer_zero) begin
                    state_d = SAMPLE;
                end else begin
                    w_timer_dec = 1'b1;
                end
            end
            SAMPLE: begin
                obs_d = w_obs_final;
                if (vec_q == 2'd3) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    fail_mask_d = w_obs_final ^ EXP_TT;
                    pass_d      = (w_obs_final == EXP_TT);
                    ab_d        = 2'd0;
                end else begin
                    state_d      = SETTLE;
                    vec_d        = vec_q + 2'd1;
                    ab_d         = vec_q + 2'd1;
                    w_timer_load = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
    end

    assign bus.a           = ab_q[1];
    assign bus.b           = ab_q[0];
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.fail_mask   = fail_mask_q;
    assign bus.observed_tt = obs_q;

endmodule : gate_tt_checker
`default_nettype wire

// File: tb/tb_gate_tt_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_tt_checker
// Purpose  : Directed self-checking bench for gate_tt_checker. Instance 0
//            uses default parameters with a switchable NOR/NAND gate model;
//            instance 1 uses SETTLE_CYCLES=1 with a NOR gate model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_tt_checker;
    import gate_tt_pkg::*;

    logic clk;
    logic rst_n;
    logic gate_nand;
    int   n_total;
    int   n_bad;

    gate_tt_checker_if bus0 ();
    gate_tt_checker_if bus1 ();

    // Gate-under-test models.
    assign bus0.f = gate_nand ? ~(bus0.a & bus0.b) : ~(bus0.a | bus0.b);
    assign bus1.f = ~(bus1.a | bus1.b);

    gate_tt_checker #(
        .EXP_TT        (TT_NOR),
        .SETTLE_CYCLES (2)
    ) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    gate_tt_checker #(
        .EXP_TT        (TT_NOR),
        .SETTLE_CYCLES (1)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One run on instance 0 with defaults: vector period 3, done after E+12.
    // mid_k >= 0 pulses start once more, just before edge E+mid_k+1.
    task automatic run0(input logic [3:0] exp_obs, input logic [3:0] exp_fail,
                        input logic exp_pass, input int mid_k, input string tag);
        logic [1:0] exp_ab;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        check_eq($sformatf("%s_acc_pass", tag), 32'(bus0.pass), 32'd0);
        for (int k = 0; k <= 14; k++) begin
            exp_ab = (k < 12) ? 2'(k / 3) : 2'd0;
            check_eq($sformatf("%s_ab_k%0d", tag, k), 32'({bus0.a, bus0.b}), 32'(exp_ab));
            check_eq($sformatf("%s_done_k%0d", tag, k), 32'(bus0.done), 32'(k == 12));
            check_eq($sformatf("%s_busy_k%0d", tag, k), 32'(bus0.busy), 32'(k < 12));
            if (k == 12) begin
                check_eq($sformatf("%s_obs", tag), 32'(bus0.observed_tt), 32'(exp_obs));
                check_eq($sformatf("%s_fmask", tag), 32'(bus0.fail_mask), 32'(exp_fail));
                check_eq($sformatf("%s_pass", tag), 32'(bus0.pass), 32'(exp_pass));
            end
            if (k == mid_k) bus0.start = 1'b1;
            tick();
            bus0.start = 1'b0;
        end
    endtask

    initial begin
        logic [1:0] exp_ab;
        n_total    = 0;
        n_bad      = 0;
        gate_nand  = 1'b0;
        rst_n      = 1'b0;
        bus0.start = 1'b0;
        bus1.start = 1'b0;

        // Reset state.
        tick();
        tick();
        check_eq("rst_ab",   32'({bus0.a, bus0.b}), 32'd0);
        check_eq("rst_busy", 32'(bus0.busy), 32'd0);
        check_eq("rst_done", 32'(bus0.done), 32'd0);
        check_eq("rst_pass", 32'(bus0.pass), 32'd0);
        check_eq("rst_fmask", 32'(bus0.fail_mask), 32'd0);
        check_eq("rst_obs",  32'(bus0.observed_tt), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        tick();
        check_eq("idle_busy", 32'(bus0.busy), 32'd0);

        // Correct NOR gate.
        run0(4'b0001, 4'b0000, 1'b1, -1, "nor");

        // NAND gate against NOR expectation.
        gate_nand = 1'b1;
        run0(4'b0111, 4'b0110, 1'b0, -1, "nand");
        gate_nand = 1'b0;

        // SETTLE_CYCLES=1 instance: vector period 2, done after E+8.
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            exp_ab = (k < 8) ? 2'(k / 2) : 2'd0;
            check_eq($sformatf("s1_ab_k%0d", k), 32'({bus1.a, bus1.b}), 32'(exp_ab));
            check_eq($sformatf("s1_done_k%0d", k), 32'(bus1.done), 32'(k == 8));
            if (k == 8) begin
                check_eq("s1_obs",  32'(bus1.observed_tt), 32'(4'b0001));
                check_eq("s1_pass", 32'(bus1.pass), 32'd1);
            end
            tick();
        end

        // Restart attempt mid-run (vec=2) is ignored; then a clean rerun.
        run0(4'b0001, 4'b0000, 1'b1, 6, "mid");
        check_eq("mid_pass_held", 32'(bus0.pass), 32'd1);
        run0(4'b0001, 4'b0000, 1'b1, -1, "rerun");

        // Async reset during SETTLE of vec=1.
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check_eq("ar_pre_ab",  32'({bus0.a, bus0.b}), 32'd1);
        check_eq("ar_pre_obs", 32'(bus0.observed_tt), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("ar_ab",   32'({bus0.a, bus0.b}), 32'd0);
        check_eq("ar_busy", 32'(bus0.busy), 32'd0);
        check_eq("ar_pass", 32'(bus0.pass), 32'd0);
        check_eq("ar_obs",  32'(bus0.observed_tt), 32'd0);
        tick();
        #2 rst_n = 1'b1;
        for (int k = 0; k < 14; k++) begin
            tick();
            check_eq($sformatf("ar_nodone_k%0d", k), 32'(bus0.done), 32'd0);
        end
        run0(4'b0001, 4'b0000, 1'b1, -1, "post_rst");

        // start held high: back-to-back runs with one IDLE cycle between.
        bus0.start = 1'b1;
        tick();
        for (int k = 1; k <= 26; k++) begin
            tick();
            if (k == 12 || k == 26) begin
                check_eq($sformatf("b2b_done_k%0d", k), 32'(bus0.done), 32'd1);
                check_eq($sformatf("b2b_pass_k%0d", k), 32'(bus0.pass), 32'd1);
            end
            if (k == 13) begin
                check_eq("b2b_idle_busy", 32'(bus0.busy), 32'd0);
                check_eq("b2b_idle_done", 32'(bus0.done), 32'd0);
                check_eq("b2b_idle_pass", 32'(bus0.pass), 32'd1);
            end
            if (k == 14) begin
                check_eq("b2b_acc_busy", 32'(bus0.busy), 32'd1);
                check_eq("b2b_acc_pass", 32'(bus0.pass), 32'd0);
            end
        end
        bus0.start = 1'b0;
        tick();
        tick();
        check_eq("end_busy", 32'(bus0.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_gate_tt_checker
`default_nettype wire
